riscv_instr_mem_responder: RTL



---
 rtl/riscv_instr_mem_responder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/riscv_instr_mem_responder.sv
// Instruction-fetch memory responder: grant wait states, fixed read latency, in-order responses.
// Optional grant-stall randomisation is enabled by defining RESP_STALL_LFSR_EN.
module riscv_instr_mem_responder #(
  parameter int unsigned ADDR_WIDTH      = 12,
  parameter int unsigned GNT_WAIT        = 0,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_req_i,
  input  logic [31:0]           instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [31:0]           instr_rdata_o,
  input  logic                  load_we_i,
  input  logic [ADDR_WIDTH-1:0] load_addr_i,
  input  logic [31:0]           load_wdata_i,
  output logic                  busy_o
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [3:0]  WAIT_LOAD = (GNT_WAIT == 0) ? 4'd0 : 4'(GNT_WAIT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, GNT} state_t;

  state_t                  state;
  logic [3:0]              wait_cnt;
  logic [CNT_W-1:0]        outstanding;
  logic                    slot_ok;
  logic                    gnt_raw;
  logic                    gnt;
  logic                    hs;
  logic [ADDR_WIDTH-1:0]   hs_idx;
  logic                    fin_vld;
  logic [ADDR_WIDTH-1:0]   fin_idx;
  logic [DATA_W-1:0]       mem [2**ADDR_WIDTH];
  logic                    unused_addr_bits;

  // A response retiring this cycle frees its slot for a same-cycle grant.
  assign slot_ok = (outstanding < CNT_W'(MAX_OUTSTANDING)) | instr_rvalid_o;

  always_comb begin
    gnt_raw = 1'b0;
    case (state)
      IDLE:    gnt_raw = instr_req_i & (GNT_WAIT == 0) & slot_ok;
      GNT:     gnt_raw = instr_req_i & slot_ok;
      default: gnt_raw = 1'b0;
    endcase
  end

`ifdef RESP_STALL_LFSR_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign gnt = gnt_raw & ~lfsr[0] & rst_n;
`else
  assign gnt = gnt_raw & rst_n;
`endif

  assign instr_gnt_o      = gnt;
  assign hs               = instr_req_i & gnt;
  assign hs_idx           = instr_addr_i[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{instr_addr_i[31:ADDR_WIDTH+2], instr_addr_i[1:0]};

  // The wait ends when the counter reaches zero, so gnt lands exactly GNT_WAIT cycles after req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_req_i && (GNT_WAIT != 0)) begin
            wait_cnt <= WAIT_LOAD;
            state    <= (WAIT_LOAD == 4'd0) ? GNT : WAIT;
          end
        end
        WAIT: begin
          if (!instr_req_i) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
            if (wait_cnt == 4'd1) state <= GNT;
          end
        end
        GNT: begin
          if (!instr_req_i) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
          end else if (gnt) begin
            state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          wait_cnt <= 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else if (hs && !instr_rvalid_o) begin
      outstanding <= outstanding + CNT_W'(1);
    end else if (!hs && instr_rvalid_o) begin
      outstanding <= outstanding - CNT_W'(1);
    end
  end

  assign busy_o = (outstanding != '0) | (state != IDLE);

  // ---- stage p0: handshake; stages p1..pLATENCY-1: delay line ahead of the array read ----
  if (LATENCY == 1) begin : g_lat1
    assign fin_vld = hs;
    assign fin_idx = hs_idx;
  end else begin : g_latn
    logic                  vld_p [1:LATENCY-1];
    logic [ADDR_WIDTH-1:0] idx_p [1:LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 1; i < LATENCY; i++) vld_p[i] <= 1'b0;
      end else begin
        vld_p[1] <= hs;
        for (int i = 2; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
      end
    end

    always_ff @(posedge clk) begin
      idx_p[1] <= hs_idx;
      for (int i = 2; i < LATENCY; i++) idx_p[i] <= idx_p[i-1];
    end

    assign fin_vld = vld_p[LATENCY-1];
    assign fin_idx = idx_p[LATENCY-1];
  end

  // ---- final stage: array read into the registered response (read-first against the load port) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_rvalid_o <= 1'b0;
      instr_rdata_o  <= '0;
    end else begin
      instr_rvalid_o <= fin_vld;
      if (fin_vld) instr_rdata_o <= mem[fin_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (load_we_i) mem[load_addr_i] <= load_wdata_i;
  end

endmodule
